mux_rr_arbiter: RTL and testbench



---
 rtl/mux_rr_arbiter_pkg.sv | 20 ++
 rtl/mux_rr_arbiter_if.sv | 24 ++
 rtl/mux_rr_arbiter_mux4.sv | 10 +
 rtl/mux_rr_arbiter_rr_pick.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 185 ++++++++++++++++++
 6 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package mux_ctrl_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // With last = 3 the first scan position is source 0.
  localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

  // Index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bundle of the arbiter: requests, data and the arbitrated result.
interface mux_rr_arbiter_if;
  import mux_ctrl_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] d;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             y;
  logic             valid;

  // Requesters drive req/d and observe the result.
  modport master (
    output req, d,
    input  grant, sel, y, valid
  );

  // The arbiter owns grant, the mux select and the registered mux output.
  modport slave (
    input  req, d,
    output grant, sel, y, valid
  );

endinterface

// File: rtl/mux_rr_arbiter_mux4.sv
// Existing dataflow 4:1 mux (D[3:0], S[1:0] -> y).
module mux4 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req scanning last+1 .. last+4 (mod N_REQ).
module rr_pick
  import mux_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  // Scan in round-robin order; the first hit is latched by the !any guard.
  always_comb begin
    logic [SEL_W-1:0] idx;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = last + SEL_W'(k);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of the 4:1 mux; owns the mux select.
module mux_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_rr_arbiter_if.slave bus
);

  state_e           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             y_q;
  logic             valid_q;

  logic [SEL_W-1:0] win;
  logic             any;
  logic             mux_y;
  logic             hold_limit;
  logic             release_now;

  // In GRANT last_q always equals sel_q, so one picker serves both the idle
  // decision and the release re-pick with the holder at lowest priority.
  rr_pick u_pick (
    .req  (bus.req),
    .last (last_q),
    .win  (win),
    .any  (any)
  );

  mux4 u_mux (
    .d (bus.d),
    .s (sel_q),
    .y (mux_y)
  );

  // Release when the holder drops its request or has used its hold budget.
  always_comb begin
    hold_limit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
    release_now = !bus.req[sel_q] || hold_limit;
  end

  // Arbitration FSM with registered grant/select/data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_q == ST_GRANT);
      unique case (state_q)
        ST_IDLE: begin
          if (any) begin
            state_q <= ST_GRANT;
            grant_q <= onehot(win);
            sel_q   <= win;
            last_q  <= win;
            cnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          y_q <= mux_y;
          if (!release_now) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else if (any) begin
            // Handoff (or self re-grant) at the same edge, no idle bubble.
            grant_q <= onehot(win);
            sel_q   <= win;
            last_q  <= win;
            cnt_q   <= '0;
          end else begin
            // sel is left alone so the mux keeps its last select.
            state_q <= ST_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.y     = y_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: vector table plus hand sequences, scoreboard-checked.
module tb_mux_rr_arbiter;
  import mux_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(
    .MAX_HOLD (8),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       y;
    logic       valid;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       y;
    logic       valid;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[18];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input logic [3:0] g, input logic [1:0] s, input logic y,
                      input logic v, input string n);
    exp_t e;
    e.grant = g;
    e.sel   = s;
    e.y     = y;
    e.valid = v;
    e.name  = n;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if ({bus.grant, bus.sel, bus.y, bus.valid} !== {e.grant, e.sel, e.y, e.valid}) begin
      errors++;
      $display("FAIL %s: got grant=%b sel=%0d y=%b valid=%b, want grant=%b sel=%0d y=%b valid=%b",
               e.name, bus.grant, bus.sel, bus.y, bus.valid, e.grant, e.sel, e.y, e.valid);
    end
  endtask

  // Drive inputs, queue what must appear after the next edge, then compare.
  task automatic step(input logic [3:0] r, input logic [3:0] dd, input logic [3:0] g,
                      input logic [1:0] s, input logic y, input logic v, input string n);
    bus.req = r;
    bus.d   = dd;
    push(g, s, y, v, n);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset(input logic [3:0] r, input logic [3:0] dd);
    rst_n   = 1'b0;
    bus.req = r;
    bus.d   = dd;
    push(4'b0000, 2'd0, 1'b0, 1'b0, "reset_state");
    repeat (2) @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dv;
    logic [1:0] own;
    logic [1:0] prv;

    bus.req = '0;
    bus.d   = '0;

    tbl[0]  = '{4'b0010, 4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[2]  = '{4'b0010, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[3]  = '{4'b0010, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{4'b0010, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0110, 4'b0000, 2'd1, 1'b1, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0110, 4'b0000, 2'd1, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0110, 4'b0000, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{4'b0000, 4'b1001, 4'b0000, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[10] = '{4'b1001, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[11] = '{4'b0001, 4'b0111, 4'b0001, 2'd0, 1'b0, 1'b1};
    tbl[12] = '{4'b0001, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[13] = '{4'b0101, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[14] = '{4'b0100, 4'b0111, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[15] = '{4'b0100, 4'b0011, 4'b0100, 2'd2, 1'b0, 1'b1};
    tbl[16] = '{4'b0000, 4'b0011, 4'b0000, 2'd2, 1'b0, 1'b1};
    tbl[17] = '{4'b0000, 4'b0011, 4'b0000, 2'd2, 1'b0, 1'b0};

    // Reset with all requesting, then full round-robin rotation (8 cycles each).
    dv = 4'b0110;
    do_reset(4'b1111, dv);
    for (int c = 1; c <= 40; c++) begin
      own = 2'((c - 1) / 8);
      prv = (c >= 2) ? 2'((c - 2) / 8) : 2'd0;
      step(4'b1111, dv, onehot(own), own, (c >= 2) ? dv[prv] : 1'b0, c >= 2,
           $sformatf("rr_c%0d", c));
    end

    // Table: basic select, idle hold, handoff, masked toggles.
    do_reset(4'b0000, 4'b0110);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, tbl[i].d, tbl[i].grant, tbl[i].sel, tbl[i].y, tbl[i].valid,
           $sformatf("tbl_%0d", i));
    end

    // Early release: source 2 drops, source 0 takes over and gets a full budget.
    do_reset(4'b0000, 4'b0110);
    step(4'b0100, 4'b0110, 4'b0100, 2'd2, 1'b0, 1'b0, "er_grant2");
    step(4'b0101, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b1, "er_hold_a");
    step(4'b0101, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b1, "er_hold_b");
    step(4'b0011, 4'b0110, 4'b0001, 2'd0, 1'b1, 1'b1, "er_handoff");
    for (int k = 1; k <= 7; k++) begin
      step(4'b0011, 4'b0110, 4'b0001, 2'd0, 1'b0, 1'b1, $sformatf("er_src0_%0d", k));
    end
    step(4'b0011, 4'b0110, 4'b0010, 2'd1, 1'b0, 1'b1, "er_limit_to_src1");

    // Sole holder re-granted to itself across hold-limit wraps.
    do_reset(4'b0000, 4'b1000);
    step(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0, "sole_grant");
    for (int k = 1; k <= 20; k++) begin
      step(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, $sformatf("sole_%0d", k));
    end

    // Asynchronous reset in the middle of a grant.
    do_reset(4'b0000, 4'b0110);
    step(4'b0110, 4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0, "mr_grant");
    step(4'b0110, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1, "mr_c2");
    step(4'b0110, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1, "mr_c3");
    #2;
    rst_n = 1'b0;
    #1;
    push(4'b0000, 2'd0, 1'b0, 1'b0, "mr_async_reset");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0110, 4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0, "mr_post_reset_grant");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
